// File: rtl/router_reg_if.sv
// rtl/router_reg_if.sv - source, FSM-decode and destination-side signals of the router register block
interface router_reg_if;
  logic       pkt_valid;
  logic [7:0] data_in;
  logic       fifo_full;
  logic       detect_add;
  logic       lfd_state;
  logic       ld_state;
  logic       laf_state;
  logic       full_state;
  logic       rst_int_reg;
  logic [7:0] dout;
  logic       parity_done;
  logic       low_packet_valid;
  logic       err;

  // Drives the source byte stream and FSM decodes, observes the register outputs
  modport master (
    output pkt_valid, data_in, fifo_full,
    output detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_packet_valid, err
  );

  // The register block itself
  modport slave (
    input  pkt_valid, data_in, fifo_full,
    input  detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_packet_valid, err
  );
endinterface

// File: rtl/router_reg.sv
// rtl/router_reg.sv - router datapath registers: header/hold capture, byte output and parity check
module router_reg (
  input logic         clock,
  input logic         resetn,
  router_reg_if.slave bus
);

  logic [7:0] dout_q, dout_d;
  logic [7:0] header_q, header_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_is_parity_q, hold_is_parity_d;
  logic [7:0] int_parity_q, int_parity_d;
  logic [7:0] pkt_parity_q, pkt_parity_d;
  logic       parity_done_q, parity_done_d;
  logic       low_pv_q, low_pv_d;
  logic       err_q, err_d;
  // Remembers that the held byte was already replayed in this LOAD_AFTER_FULL visit
  logic       laf_done_q, laf_done_d;

  // Next-state decode; priority chain resolves overlapping decodes
  always_comb begin
    dout_d           = dout_q;
    header_d         = header_q;
    hold_d           = hold_q;
    hold_is_parity_d = hold_is_parity_q;
    int_parity_d     = int_parity_q;
    pkt_parity_d     = pkt_parity_q;
    parity_done_d    = parity_done_q;
    low_pv_d         = low_pv_q;
    err_d            = err_q;
    laf_done_d       = 1'b0;

    if (bus.detect_add) begin
      // Address 2'b11 is not a valid destination, so the old header is kept
      if (bus.pkt_valid && (bus.data_in[1:0] != 2'b11)) begin
        header_d = bus.data_in;
      end
      if (bus.pkt_valid) begin
        err_d = 1'b0;
      end
      int_parity_d     = 8'h00;
      pkt_parity_d     = 8'h00;
      parity_done_d    = 1'b0;
      low_pv_d         = 1'b0;
      hold_is_parity_d = 1'b0;
    end else if (bus.lfd_state) begin
      dout_d       = header_q;
      int_parity_d = header_q;
    end else if (bus.ld_state) begin
      // pkt_valid low marks the parity byte whether or not it can be written yet
      if (!bus.pkt_valid) begin
        low_pv_d = 1'b1;
      end
      if (bus.fifo_full) begin
        hold_d           = bus.data_in;
        hold_is_parity_d = ~bus.pkt_valid;
      end else begin
        dout_d = bus.data_in;
        if (bus.pkt_valid) begin
          int_parity_d = int_parity_q ^ bus.data_in;
        end else begin
          pkt_parity_d  = bus.data_in;
          parity_done_d = 1'b1;
        end
      end
    end else if (bus.laf_state) begin
      // Replay the byte that was blocked by a full FIFO, only on the first cycle
      if (!laf_done_q) begin
        dout_d = hold_q;
        if (hold_is_parity_q) begin
          pkt_parity_d  = hold_q;
          parity_done_d = 1'b1;
        end else begin
          int_parity_d = int_parity_q ^ hold_q;
        end
        hold_is_parity_d = 1'b0;
      end
      laf_done_d = 1'b1;
    end else if (bus.rst_int_reg) begin
      err_d    = (int_parity_q != pkt_parity_q);
      low_pv_d = 1'b0;
    end else if (bus.full_state) begin
      laf_done_d = laf_done_q;
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      dout_q           <= 8'h00;
      header_q         <= 8'h00;
      hold_q           <= 8'h00;
      hold_is_parity_q <= 1'b0;
      int_parity_q     <= 8'h00;
      pkt_parity_q     <= 8'h00;
      parity_done_q    <= 1'b0;
      low_pv_q         <= 1'b0;
      err_q            <= 1'b0;
      laf_done_q       <= 1'b0;
    end else begin
      dout_q           <= dout_d;
      header_q         <= header_d;
      hold_q           <= hold_d;
      hold_is_parity_q <= hold_is_parity_d;
      int_parity_q     <= int_parity_d;
      pkt_parity_q     <= pkt_parity_d;
      parity_done_q    <= parity_done_d;
      low_pv_q         <= low_pv_d;
      err_q            <= err_d;
      laf_done_q       <= laf_done_d;
    end
  end

  assign bus.dout             = dout_q;
  assign bus.parity_done      = parity_done_q;
  assign bus.low_packet_valid = low_pv_q;
  assign bus.err              = err_q;

endmodule
